// File: rtl/edge_detect_pkg.sv
// Shared constants and types for the Sobel-lite edge detector.
package edge_detect_pkg;
    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;

    localparam logic [23:0] EDGE_PIX    = 24'h000000;
    localparam logic [23:0] NONEDGE_PIX = 24'hFFFFFF;

    typedef logic [23:0] rgb_t;
    typedef logic [7:0]  luma_t;

    // Counter width that stays legal for degenerate 1-pixel dimensions.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/edge_detect_if.sv
// Pixel stream in, edge/colour stream out.
interface edge_detect_if;
    import edge_detect_pkg::*;

    rgb_t  pixel_in;
    logic  pixel_valid;
    logic  sof;
    luma_t threshold;
    rgb_t  edgeDet;
    rgb_t  colorRed;
    logic  out_valid;

    modport master (output pixel_in, pixel_valid, sof, threshold,
                    input  edgeDet, colorRed, out_valid);
    modport slave  (input  pixel_in, pixel_valid, sof, threshold,
                    output edgeDet, colorRed, out_valid);
endinterface

// File: rtl/edge_detect_line_buffer.sv
// Single-port read-before-write line store; contents are never reset so it maps to block RAM.
module line_buffer #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 640,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_rdata        <= r_mem[i_addr];
            r_mem[i_addr]  <= i_wdata;
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/edge_detect.sv
// Two-stage luma gradient edge detector: stage 1 gathers Y and neighbours,
// stage 2 thresholds |dh|+|dv| and emits black (edge) or white pixels.
module edge_detect
    import edge_detect_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic          clk,
    input  logic          reset,
    edge_detect_if.slave  bus
);
    localparam int XW     = cnt_w(IMG_WIDTH);
    localparam int YW     = cnt_w(IMG_HEIGHT);
    localparam int STAGES = 2;

    logic [XW-1:0]     r_x, w_x;
    logic [YW-1:0]     r_y, w_row;
    logic [STAGES:1]   r_vld_pipe;
    logic [9:0]        w_sum;
    luma_t             w_luma, w_up, r_prev_y;
    luma_t             r_luma1, r_left1, r_thr1;
    rgb_t              r_rgb1, r_edge, r_color;
    logic              r_xz1, r_yz1;
    luma_t             w_dh, w_dv, w_g;
    logic [8:0]        w_g9;
    logic              w_edge;

    // sof forces this pixel to (0,0) regardless of where the counters are.
    assign w_x   = bus.sof ? '0 : r_x;
    assign w_row = bus.sof ? '0 : r_y;

    assign w_sum  = {2'b00, bus.pixel_in[23:16]} + {1'b0, bus.pixel_in[15:8], 1'b0}
                  + {2'b00, bus.pixel_in[7:0]};
    assign w_luma = w_sum[9:2];

    line_buffer #(.WIDTH(8), .DEPTH(IMG_WIDTH)) u_lb (
        .clk     (clk),
        .i_en    (bus.pixel_valid & ~reset),
        .i_addr  (w_x),
        .i_wdata (w_luma),
        .o_rdata (w_up)
    );

    assign w_dh   = r_xz1 ? '0 : ((r_luma1 >= r_left1) ? r_luma1 - r_left1 : r_left1 - r_luma1);
    assign w_dv   = r_yz1 ? '0 : ((r_luma1 >= w_up)    ? r_luma1 - w_up    : w_up - r_luma1);
    assign w_g9   = {1'b0, w_dh} + {1'b0, w_dv};
    assign w_g    = w_g9[8] ? 8'hFF : w_g9[7:0];
    assign w_edge = (w_g > r_thr1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_prev_y   <= '0;
            r_vld_pipe <= '0;
            r_edge     <= NONEDGE_PIX;
            r_color    <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], bus.pixel_valid};
            if (bus.pixel_valid) begin
                if (w_x == XW'(IMG_WIDTH - 1)) begin
                    r_x <= '0;
                    r_y <= (w_row == YW'(IMG_HEIGHT - 1)) ? '0 : w_row + YW'(1);
                end else begin
                    r_x <= w_x + XW'(1);
                    r_y <= w_row;
                end
                r_prev_y <= w_luma;
                r_luma1  <= w_luma;
                r_left1  <= r_prev_y;
                r_thr1   <= bus.threshold;
                r_rgb1   <= bus.pixel_in;
                r_xz1    <= (w_x == '0);
                r_yz1    <= (w_row == '0);
            end
            if (r_vld_pipe[1]) begin
                r_edge  <= w_edge ? EDGE_PIX : NONEDGE_PIX;
                r_color <= r_rgb1;
            end
        end
    end

    assign bus.edgeDet   = r_edge;
    assign bus.colorRed  = r_color;
    assign bus.out_valid = r_vld_pipe[STAGES];
endmodule

// File: tb/tb_edge_detect.sv
// Randomised bench for edge_detect on a 4x2 image against a frame-array luma model.
module tb_edge_detect;
    import edge_detect_pkg::*;

    localparam int W = 4;
    localparam int H = 2;

    typedef struct {
        int          dcyc;
        logic [23:0] e;
        logic [23:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    edge_detect_if bus();

    edge_detect #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          mx = 0;
    int          my = 0;
    int          lum[H][W];
    bit          mon_en = 1'b0;
    logic        rst_q;
    logic [1:0]  v_hist;
    logic [23:0] hold_e, hold_c;
    logic [23:0] fr[8];
    logic [23:0] r034[4];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (cycle %0d)", tag, act, exp, cyc);
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [7:0] clamp8(input int v);
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    // Half the time a fully random colour, otherwise a noisy grey so gradients land near threshold.
    function automatic logic [23:0] rpix();
        int b;
        b = int'($urandom_range(0, 255));
        if ($urandom % 2 == 0) return 24'($urandom);
        return {clamp8(b + int'($urandom_range(0, 16)) - 8),
                clamp8(b + int'($urandom_range(0, 16)) - 8),
                clamp8(b + int'($urandom_range(0, 16)) - 8)};
    endfunction

    // Drive one cycle and update the reference model with what the pixel should produce.
    task automatic cycle(input bit rst, input bit pv, input bit sf,
                         input logic [23:0] pix, input logic [7:0] thr);
        int   yv, dh, dv, g;
        exp_t e;
        reset           = rst;
        bus.pixel_valid = pv;
        bus.sof         = sf;
        bus.pixel_in    = pix;
        bus.threshold   = thr;
        if (rst) begin
            // pixels accepted last cycle or this cycle never reach the output
            while (q.size() > 0 && q[$].dcyc >= cyc - 1) void'(q.pop_back());
            mx = 0;
            my = 0;
        end else if (pv) begin
            if (sf) begin
                mx = 0;
                my = 0;
            end
            yv = (int'(pix[23:16]) + 2 * int'(pix[15:8]) + int'(pix[7:0])) / 4;
            dh = 0;
            dv = 0;
            if (mx > 0) dh = iabs(yv - lum[my][mx-1]);
            if (my > 0) dv = iabs(yv - lum[my-1][mx]);
            g = dh + dv;
            if (g > 255) g = 255;
            e.dcyc = cyc;
            e.e    = (g > int'(thr)) ? EDGE_PIX : NONEDGE_PIX;
            e.c    = pix;
            q.push_back(e);
            lum[my][mx] = yv;
            mx++;
            if (mx == W) begin
                mx = 0;
                my = (my + 1) % H;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    always @(posedge clk) begin
        rst_q  <= reset;
        v_hist <= reset ? 2'b00 : {v_hist[0], bus.pixel_valid};
    end

    always @(negedge clk) begin
        exp_t ex;
        if (mon_en) begin
            chk("out_valid", 32'(bus.out_valid), 32'(v_hist[1]));
            if (bus.out_valid) begin
                chk("queue_nonempty", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    ex = q.pop_front();
                    chk("edgeDet", 32'(bus.edgeDet), 32'(ex.e));
                    chk("colorRed", 32'(bus.colorRed), 32'(ex.c));
                    hold_e = ex.e;
                    hold_c = ex.c;
                end
            end else begin
                if (rst_q) begin
                    hold_e = NONEDGE_PIX;
                    hold_c = 24'h000000;
                end
                chk("hold_edgeDet", 32'(bus.edgeDet), 32'(hold_e));
                chk("hold_colorRed", 32'(bus.colorRed), 32'(hold_c));
            end
        end
    end

    initial begin
        logic [7:0] thr;
        bit         pv;
        reset           = 1'b1;
        bus.pixel_valid = 1'b0;
        bus.sof         = 1'b0;
        bus.pixel_in    = '0;
        bus.threshold   = '0;
        r034 = '{24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF};

        cycle(1, 0, 0, '0, '0);
        mon_en = 1'b1;
        cycle(1, 0, 0, '0, '0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_edgeDet", 32'(bus.edgeDet), 32'hFFFFFF);
        chk("rst_colorRed", 32'(bus.colorRed), 32'h000000);

        // flat grey frame, threshold 0: nothing is an edge
        for (int i = 0; i < 8; i++) cycle(0, 1, i == 0, 24'h808080, 8'd0);
        // black->white step inside row 0
        for (int i = 0; i < 8; i++) cycle(0, 1, i == 0, r034[i % 4], 8'd100);
        // black row over white row
        for (int i = 0; i < 8; i++) cycle(0, 1, i == 0, (i < 4) ? 24'h000000 : 24'hFFFFFF, 8'd254);
        // gradient of exactly 50 at threshold 50 and 49
        cycle(0, 1, 1, 24'h000000, 8'd50);
        cycle(0, 1, 0, 24'h323232, 8'd50);
        cycle(0, 1, 1, 24'h000000, 8'd49);
        cycle(0, 1, 0, 24'h323232, 8'd49);

        // same random frame, gap-free then with three idle cycles between pixels
        thr = 8'($urandom_range(0, 80));
        for (int i = 0; i < 8; i++) fr[i] = rpix();
        for (int i = 0; i < 8; i++) cycle(0, 1, i == 0, fr[i], thr);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, i == 0, fr[i], thr);
            repeat (3) cycle(0, 0, 0, 24'h5A5A5A, thr);
        end

        // random traffic: gaps, mid-frame sof, occasional reset colliding with valid/sof
        for (int i = 0; i < 400; i++) begin
            pv = ($urandom % 4) != 0;
            if ($urandom % 50 == 0)
                cycle(1, pv, $urandom % 2 == 1, rpix(), 8'($urandom));
            else
                cycle(0, pv, ($urandom % 20) == 0, rpix(), 8'($urandom_range(0, 120)));
        end

        // reset right after pixel (2,1), then a fresh frame
        for (int i = 0; i < 7; i++) cycle(0, 1, i == 0, rpix(), 8'd30);
        cycle(1, 1, 1, rpix(), 8'd30);
        for (int i = 0; i < 8; i++) cycle(0, 1, i == 0, rpix(), 8'd30);

        repeat (4) cycle(0, 0, 0, '0, '0);
        chk("drain_queue", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/edge_detect.md
EDGE_DETECT -- requirements
Module: edge_detect

Interface
REQ-001 Parameter IMG_WIDTH, default 640: pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 480: lines per frame.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pixel_in  input  24  raster-order RGB pixel {R[23:16],G[15:8],B[7:0]}.
REQ-006 pixel_valid  input  1  pixel_in valid this cycle.
REQ-007 sof  input  1  start of frame; qualified by pixel_valid; marks pixel (0,0).
REQ-008 threshold  input  8  edge decision threshold, sampled each valid pixel.
REQ-009 edgeDet  output  24  24'h000000 = edge, 24'hFFFFFF = non-edge.
REQ-010 colorRed  output  24  pixel_in delayed to align with edgeDet.
REQ-011 out_valid  output  1  edgeDet/colorRed valid this cycle.

Function
REQ-012 Luma SHALL be Y = (R + 2G + B) >> 2, computed in 10 bits, truncated to 8 bits.
REQ-013 Column counter x SHALL advance on each valid pixel and wrap from IMG_WIDTH-1 to 0, advancing row counter y.
REQ-014 Row counter y SHALL wrap from IMG_HEIGHT-1 to 0.
REQ-015 A valid pixel with sof=1 SHALL be treated as (0,0) regardless of counter state; counters then continue from (1,0).
REQ-016 Line buffer (IMG_WIDTH x 8) SHALL return the previous line's Y at column x and be written with the current Y at column x in the same cycle (read-before-write).
REQ-017 Horizontal difference dh = |Y(x,y) - Y(x-1,y)|; dh SHALL be 0 at x=0.
REQ-018 Vertical difference dv = |Y(x,y) - Y(x,y-1)|; dv SHALL be 0 at y=0.
REQ-019 Gradient g = dh + dv SHALL saturate at 255.
REQ-020 Pixel SHALL be an edge iff g > threshold (strict); g == threshold is non-edge.
REQ-021 Pipeline: stage 1 registers Y, RGB, x/y boundary flags, line-buffer read; stage 2 registers gradient decision; latency exactly 2 valid-to-valid cycles.
REQ-022 out_valid SHALL be pixel_valid delayed by 2 cycles; pipeline advances every cycle (no stall input).
REQ-023 Cycles with pixel_valid=0 SHALL not advance counters, write line buffer, or update the previous-pixel register.
REQ-024 colorRed SHALL equal pixel_in from exactly 2 cycles earlier when out_valid=1.
REQ-025 When out_valid=0, edgeDet and colorRed SHALL hold their last values.

Reset
REQ-026 On reset: x=0, y=0, previous-pixel Y=0, out_valid=0, pipeline valid bits=0, edgeDet=24'hFFFFFF, colorRed=24'h000000.
REQ-027 Line buffer contents SHALL NOT be cleared; row-0 masking (REQ-018) makes them irrelevant.
REQ-028 Reset asserted mid-frame SHALL discard in-flight pixels; next valid pixel is treated as (0,0).
REQ-029 reset SHALL take priority over pixel_valid and sof in the same cycle.

Structure
REQ-030 Shared package SHALL hold EDGE_PIX = 24'h000000, NONEDGE_PIX = 24'hFFFFFF, default IMG_WIDTH/IMG_HEIGHT.
REQ-031 Line buffer SHALL be a separate sub-module line_buffer (single-port read-before-write, parameterised width/depth), inferable as block RAM.
REQ-032 Luma, absolute difference and saturation SHALL stay inline in edge_detect.

Verification
REQ-033 Reset, then 4x2 frame (IMG_WIDTH=4, IMG_HEIGHT=2) all 24'h808080, threshold=0 -> all 8 outputs 24'hFFFFFF, out_valid 2 cycles after each input.
REQ-034 Row 0 = {000000,000000,FFFFFF,FFFFFF}, threshold=100 -> outputs {FFFFFF,FFFFFF,000000,FFFFFF} (dh=255 at x=2 only).
REQ-035 Row 0 all 000000, row 1 all FFFFFF, threshold=254 -> row 0 all FFFFFF, row 1 all 000000 (dv=255).
REQ-036 Pixel pair with g exactly 50, threshold=50 -> FFFFFF; threshold=49 -> 000000.
REQ-037 Gaps of 3 idle cycles between valid pixels -> same edgeDet sequence as gap-free run; colorRed equals inputs in order.
REQ-038 Reset asserted after pixel (2,1), then sof frame restarted -> no out_valid for discarded pixels; first output treats new pixel as (0,0) with dh=dv=0.
